// File: rtl/tag_tx_pkg.sv
// Shared types and constants for the tag localization transmit controller:
// state encodings, preamble LFSR geometry and the NCO lookup-table size.
package tag_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRMB = 3'd1,
    ST_SYNC = 3'd2,
    ST_SYMB = 3'd3,
    ST_GAP  = 3'd4
  } tx_state_e;

  localparam int LFSR_W      = 11;
  localparam int LFSR_TAP_HI = 11;
  localparam int LFSR_TAP_LO = 9;

  localparam int LUT_DEPTH = 1024;
  localparam int LUT_AW    = 10;

  // Fibonacci step for x^11 + x^9 + 1; the newest bit enters at bit 0,
  // which is also the bit that drives the preamble sample.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[LFSR_TAP_HI-1] ^ s[LFSR_TAP_LO-1]};
  endfunction

endpackage

// File: rtl/tag_tx_nco.sv
// Cos/sin lookup for the stepped-frequency symbols: a 1024-entry ROM pair
// addressed by the top bits of the phase, read combinationally.
module tag_tx_nco
  import tag_tx_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int PHASE_WIDTH = 24,
  parameter int AMP         = 16384
) (
  input  logic [PHASE_WIDTH-1:0] phase,
  output logic [DATA_WIDTH-1:0]  cos_out,
  output logic [DATA_WIDTH-1:0]  sin_out
);

  localparam real TWO_PI = 6.283185307179586;

  logic [DATA_WIDTH-1:0] cos_rom [LUT_DEPTH];
  logic [DATA_WIDTH-1:0] sin_rom [LUT_DEPTH];
  logic [LUT_AW-1:0]     addr;

  genvar gi;
  generate
    for (gi = 0; gi < LUT_DEPTH; gi++) begin : g_rom
      localparam real ANG = TWO_PI * gi / LUT_DEPTH;
      localparam real CV  = AMP * $cos(ANG);
      localparam real SV  = AMP * $sin(ANG);
      // Round half away from zero; $rtoi alone would truncate.
      localparam int COS_V = (CV >= 0.0) ? $rtoi(CV + 0.5) : -$rtoi(0.5 - CV);
      localparam int SIN_V = (SV >= 0.0) ? $rtoi(SV + 0.5) : -$rtoi(0.5 - SV);
      assign cos_rom[gi] = DATA_WIDTH'(COS_V);
      assign sin_rom[gi] = DATA_WIDTH'(SIN_V);
    end
  endgenerate

  assign addr    = phase[PHASE_WIDTH-1 -: LUT_AW];
  assign cos_out = cos_rom[addr];
  assign sin_out = sin_rom[addr];

endmodule

// File: rtl/tag_tx_ctrl.sv
// Transmit frame controller: preamble, sync pulse, stepped tones and gap,
// streamed as I/Q samples through a single AXI-stream output register.
module tag_tx_ctrl
  import tag_tx_pkg::*;
#(
  parameter int                     DATA_WIDTH     = 16,
  parameter int                     PHASE_WIDTH    = 24,
  parameter int                     NSYMB_WIDTH    = 16,
  parameter int                     GPIO_REG_WIDTH = 12,
  parameter int                     AMP            = 16384,
  parameter int                     PRMB_LEN       = 2046,
  parameter int                     NPRMB_REP      = 2,
  parameter logic [LFSR_W-1:0]      LFSR_SEED      = 11'h7FF,
  parameter int                     NSYNCP         = 16384,
  parameter int                     NSYNCN         = 16384,
  parameter int                     NSYMB          = 512,
  parameter int                     NSIG           = 32768,
  parameter logic [PHASE_WIDTH-1:0] START_PH_INC   = '0,
  parameter int                     DPH_INC        = -16384,
  parameter int                     NGAP           = 1024
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      run_tx,
  input  logic                      tx_start,
  output logic [DATA_WIDTH-1:0]     out_itdata,
  output logic [DATA_WIDTH-1:0]     out_qtdata,
  output logic                      out_tvalid,
  output logic                      out_tlast,
  input  logic                      out_tready,
  output logic                      tx_busy,
  output logic [GPIO_REG_WIDTH-1:0] fp_gpio_out,
  output logic [GPIO_REG_WIDTH-1:0] fp_gpio_ddr,
  output logic [2:0]                tx_state,
  output logic [NSYMB_WIDTH-1:0]    symbN,
  output logic [PHASE_WIDTH-1:0]    ph
);

  localparam int CW = 32;

  localparam logic [CW-1:0]          PRMB_LAST = CW'(NPRMB_REP * PRMB_LEN - 1);
  localparam logic [CW-1:0]          REP_LAST  = CW'(PRMB_LEN - 1);
  localparam logic [CW-1:0]          SYNCP_N   = CW'(NSYNCP);
  localparam logic [CW-1:0]          SYNC_LAST = CW'(NSYNCP + NSYNCN - 1);
  localparam logic [CW-1:0]          SIG_LAST  = CW'(NSIG - 1);
  localparam logic [CW-1:0]          GAP_LAST  = CW'(NGAP - 1);
  localparam logic [NSYMB_WIDTH-1:0] SYMB_LAST = NSYMB_WIDTH'(NSYMB - 1);
  localparam logic [PHASE_WIDTH-1:0] DPH       = PHASE_WIDTH'(DPH_INC);
  localparam logic [DATA_WIDTH-1:0]  POS_AMP   = DATA_WIDTH'(AMP);
  localparam logic [DATA_WIDTH-1:0]  NEG_AMP   = DATA_WIDTH'(-AMP);

  logic [1:0]             rst_sync_q, rst_sync_d;
  logic                   rst_n_int;

  tx_state_e              state_q, state_d, cur_state, nxt_state;
  logic [CW-1:0]          cnt_q, cnt_d, cur_cnt, nxt_cnt;
  logic [CW-1:0]          rep_q, rep_d, cur_rep, nxt_rep;
  logic [LFSR_W-1:0]      lfsr_q, lfsr_d, cur_lfsr, nxt_lfsr;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d, cur_phase, nxt_phase;
  logic [PHASE_WIDTH-1:0] inc_q, inc_d, cur_inc, nxt_inc;
  logic [NSYMB_WIDTH-1:0] symb_q, symb_d, cur_symb, nxt_symb;

  logic [DATA_WIDTH-1:0]  i_q, i_d, q_q, q_d;
  logic [DATA_WIDTH-1:0]  smp_i, smp_q, nco_cos, nco_sin;
  logic                   valid_q, valid_d, last_q, last_d, gpio_q, gpio_d;
  logic                   smp_last, smp_gpio;
  logic                   adv, start;

  // Reset asserts asynchronously but releases two clocks after reset_n rises.
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n_int = rst_sync_q[1];

  // Waiting for out_tvalid to drop guarantees an idle bubble between frames.
  assign adv   = out_tready | ~valid_q;
  assign start = run_tx & tx_start & adv & ~valid_q & (state_q == ST_IDLE);

  // Position of the sample about to be emitted; an accepted start emits
  // preamble sample 0 on the same edge.
  always_comb begin
    cur_state = state_q;
    cur_cnt   = cnt_q;
    cur_rep   = rep_q;
    cur_lfsr  = lfsr_q;
    cur_phase = phase_q;
    cur_inc   = inc_q;
    cur_symb  = symb_q;
    if (start) begin
      cur_state = ST_PRMB;
      cur_cnt   = '0;
      cur_rep   = '0;
      cur_lfsr  = LFSR_SEED;
    end
  end

  tag_tx_nco #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PHASE_WIDTH (PHASE_WIDTH),
    .AMP         (AMP)
  ) u_nco (
    .phase   (cur_phase),
    .cos_out (nco_cos),
    .sin_out (nco_sin)
  );

  always_comb begin
    smp_i     = '0;
    smp_q     = '0;
    smp_last  = 1'b0;
    smp_gpio  = 1'b0;
    nxt_state = cur_state;
    nxt_cnt   = cur_cnt;
    nxt_rep   = cur_rep;
    nxt_lfsr  = cur_lfsr;
    nxt_phase = cur_phase;
    nxt_inc   = cur_inc;
    nxt_symb  = cur_symb;
    case (cur_state)
      ST_PRMB: begin
        smp_i = cur_lfsr[0] ? POS_AMP : NEG_AMP;
        if (cur_rep == REP_LAST) begin
          nxt_rep  = '0;
          nxt_lfsr = LFSR_SEED;
        end else begin
          nxt_rep  = cur_rep + 1'b1;
          nxt_lfsr = lfsr_step(cur_lfsr);
        end
        if (cur_cnt == PRMB_LAST) begin
          nxt_state = ST_SYNC;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cur_cnt + 1'b1;
        end
      end
      ST_SYNC: begin
        smp_i    = (cur_cnt < SYNCP_N) ? POS_AMP : NEG_AMP;
        smp_gpio = (cur_cnt == '0);
        if (cur_cnt == SYNC_LAST) begin
          nxt_state = ST_SYMB;
          nxt_cnt   = '0;
          nxt_phase = '0;
          nxt_inc   = START_PH_INC;
          nxt_symb  = '0;
        end else begin
          nxt_cnt = cur_cnt + 1'b1;
        end
      end
      ST_SYMB: begin
        smp_i     = nco_cos;
        smp_q     = nco_sin;
        nxt_phase = cur_phase + cur_inc;
        if (cur_cnt == SIG_LAST) begin
          nxt_cnt  = '0;
          nxt_inc  = cur_inc + DPH;
          nxt_symb = cur_symb + 1'b1;
          if (cur_symb == SYMB_LAST) nxt_state = ST_GAP;
        end else begin
          nxt_cnt = cur_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (cur_cnt == GAP_LAST) begin
          smp_last  = 1'b1;
          nxt_state = ST_IDLE;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cur_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    lfsr_d  = lfsr_q;
    phase_d = phase_q;
    inc_d   = inc_q;
    symb_d  = symb_q;
    i_d     = i_q;
    q_d     = q_q;
    valid_d = valid_q;
    last_d  = last_q;
    gpio_d  = gpio_q;
    if (!run_tx) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      rep_d   = '0;
      lfsr_d  = '0;
      phase_d = '0;
      inc_d   = '0;
      symb_d  = '0;
      i_d     = '0;
      q_d     = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      gpio_d  = 1'b0;
    end else if (adv) begin
      state_d = nxt_state;
      cnt_d   = nxt_cnt;
      rep_d   = nxt_rep;
      lfsr_d  = nxt_lfsr;
      phase_d = nxt_phase;
      inc_d   = nxt_inc;
      symb_d  = nxt_symb;
      i_d     = smp_i;
      q_d     = smp_q;
      valid_d = (cur_state != ST_IDLE);
      last_d  = smp_last;
      gpio_d  = smp_gpio;
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rep_q   <= '0;
      lfsr_q  <= '0;
      phase_q <= '0;
      inc_q   <= '0;
      symb_q  <= '0;
      i_q     <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      gpio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      lfsr_q  <= lfsr_d;
      phase_q <= phase_d;
      inc_q   <= inc_d;
      symb_q  <= symb_d;
      i_q     <= i_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      gpio_q  <= gpio_d;
    end
  end

  assign out_itdata  = i_q;
  assign out_qtdata  = q_q;
  assign out_tvalid  = valid_q;
  assign out_tlast   = last_q;
  assign tx_busy     = (state_q != ST_IDLE);
  assign tx_state    = state_q;
  assign symbN       = symb_q;
  assign ph          = phase_q;
  assign fp_gpio_out = {{(GPIO_REG_WIDTH-1){1'b0}}, gpio_q};
  assign fp_gpio_ddr = GPIO_REG_WIDTH'(1);

endmodule
